// File: rtl/proc_io_console_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | proc_io_console_pkg: shared state codes for the host I/O console    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package proc_io_console_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESENT   = 3'd1,
    S_STROBE    = 3'd2,
    S_WAIT_EXIT = 3'd3,
    S_HALTED    = 3'd4
  } io_state_t;

  // Control-unit DisplayState codes, shared with the processor's control unit.
  localparam logic [3:0] c_ST_INPUT  = 4'd5;
  localparam logic [3:0] c_ST_OUTPUT = 4'd6;

endpackage
`default_nettype wire

// File: rtl/proc_io_console_io_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | io_fifo: DEPTH x 8 circular FIFO with count, full and empty         |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module io_fifo
  import proc_io_console_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [7:0]               i_wdata,
  input  logic                     i_pop,
  output logic [7:0]               o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/proc_io_console.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | proc_io_console: host-side in/enter/out/halt console for the CPU    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module proc_io_console
  import proc_io_console_pkg::*;
#(
  parameter int         DEPTH        = 8,
  parameter logic [3:0] ST_INPUT     = c_ST_INPUT,
  parameter logic [3:0] ST_OUTPUT    = c_ST_OUTPUT,
  parameter int         ENTER_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             i_host_data,
  input  logic                   i_host_valid,
  output logic                   o_host_ready,
  input  logic [3:0]             i_cpu_state,
  input  logic [7:0]             i_cpu_out,
  input  logic                   i_cpu_halt,
  output logic [7:0]             o_cpu_in,
  output logic                   o_cpu_enter,
  output logic [7:0]             o_out_data,
  output logic                   o_out_valid,
  output logic                   o_in_waiting,
  output logic                   o_halted,
  output logic [$clog2(DEPTH):0] o_fifo_count
);

  localparam int CW = (ENTER_CYCLES > 1) ? $clog2(ENTER_CYCLES) : 1;

  io_state_t   r_state;
  io_state_t   w_next;
  logic [CW-1:0] r_strobe_cnt;
  logic [7:0]  r_cpu_in;
  logic [3:0]  r_prev_state;
  logic [7:0]  r_out_data;
  logic        r_out_valid;

  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [7:0]  w_fifo_rdata;
  logic        w_push;
  logic        w_pop;
  logic        w_in_state;
  logic        w_capture;

  assign w_in_state = (i_cpu_state == ST_INPUT);
  assign w_push     = i_host_valid && !w_fifo_full;
  // Halt wins over a pending pop so the queue is left untouched.
  assign w_pop      = (r_state == S_IDLE) && w_in_state && !w_fifo_empty && !i_cpu_halt;
  assign w_capture  = (r_prev_state == ST_OUTPUT) && (i_cpu_state != ST_OUTPUT);

  io_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (i_host_data),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (o_fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_strobe_cnt <= '0;
      r_cpu_in     <= '0;
    end else begin
      r_state      <= w_next;
      r_strobe_cnt <= (r_state == S_STROBE) ? r_strobe_cnt + 1'b1 : '0;
      if (w_pop) r_cpu_in <= w_fifo_rdata;
    end
  end

  always_comb begin
    w_next = r_state;
    if (i_cpu_halt) begin
      w_next = S_HALTED;
    end else begin
      case (r_state)
        S_IDLE:      if (w_pop) w_next = S_PRESENT;
        S_PRESENT:   w_next = S_STROBE;
        S_STROBE:    if (r_strobe_cnt == CW'(ENTER_CYCLES - 1)) w_next = S_WAIT_EXIT;
        S_WAIT_EXIT: if (!w_in_state) w_next = S_IDLE;
        S_HALTED:    w_next = S_HALTED;
        default:     w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_cpu_enter  = (r_state == S_STROBE);
    o_halted     = (r_state == S_HALTED);
    o_in_waiting = w_in_state && w_fifo_empty && (r_state != S_HALTED);
    o_host_ready = !w_fifo_full;
    o_cpu_in     = r_cpu_in;
    o_out_data   = r_out_data;
    o_out_valid  = r_out_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_state <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      r_prev_state <= i_cpu_state;
      r_out_valid  <= w_capture;
      if (w_capture) r_out_data <= i_cpu_out;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_proc_io_console.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_proc_io_console: directed scoreboard bench for proc_io_console   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_proc_io_console;

  localparam int DEPTH        = 8;
  localparam int ENTER_CYCLES = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_host_data;
  logic       i_host_valid;
  logic       o_host_ready;
  logic [3:0] i_cpu_state;
  logic [7:0] i_cpu_out;
  logic       i_cpu_halt;
  logic [7:0] o_cpu_in;
  logic       o_cpu_enter;
  logic [7:0] o_out_data;
  logic       o_out_valid;
  logic       o_in_waiting;
  logic       o_halted;
  logic [3:0] o_fifo_count;

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt = 0;
  logic [7:0] sb_in[$];
  logic [7:0] sb_out[$];

  proc_io_console #(
    .DEPTH        (DEPTH),
    .ST_INPUT     (4'd5),
    .ST_OUTPUT    (4'd6),
    .ENTER_CYCLES (ENTER_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_host_data  (i_host_data),
    .i_host_valid (i_host_valid),
    .o_host_ready (o_host_ready),
    .i_cpu_state  (i_cpu_state),
    .i_cpu_out    (i_cpu_out),
    .i_cpu_halt   (i_cpu_halt),
    .o_cpu_in     (o_cpu_in),
    .o_cpu_enter  (o_cpu_enter),
    .o_out_data   (o_out_data),
    .o_out_valid  (o_out_valid),
    .o_in_waiting (o_in_waiting),
    .o_halted     (o_halted),
    .o_fifo_count (o_fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && o_out_valid) pulse_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push(input logic [7:0] d, input bit expect_accept);
    i_host_data  = d;
    i_host_valid = 1'b1;
    step();
    i_host_valid = 1'b0;
    if (expect_accept) sb_in.push_back(d);
  endtask

  task automatic present_byte();
    int n;
    int highs;
    logic [7:0] exp;
    i_cpu_state = 4'd5;
    n = 0;
    while (!o_cpu_enter && n < 20) begin step(); n++; end
    exp = (sb_in.size() > 0) ? sb_in.pop_front() : 8'h00;
    check("enter_seen", o_cpu_enter, 1);
    check("cpu_in", o_cpu_in, exp);
    n = 0;
    while (o_cpu_enter && n < 10) begin step(); n++; end
    check("enter_len", n, ENTER_CYCLES);
    highs = 0;
    for (int i = 0; i < 3; i++) begin step(); if (o_cpu_enter) highs++; end
    check("no_second_enter", highs, 0);
    i_cpu_state = 4'd2;
    step();
    step();
    check("cpu_in_held", o_cpu_in, exp);
  endtask

  task automatic do_output(input logic [7:0] v);
    int n;
    i_cpu_out   = v;
    i_cpu_state = 4'd6;
    step();
    step();
    i_cpu_state = 4'd2;
    sb_out.push_back(v);
    step();
    n = 1;
    while (!o_out_valid && n < 5) begin step(); n++; end
    check("cap_latency", n, 1);
    check("out_data", o_out_data, sb_out.pop_front());
    step();
    check("out_valid_single", o_out_valid, 0);
  endtask

  initial begin
    int n;
    int p0;
    rst = 1'b1;
    i_host_data = '0; i_host_valid = 1'b0; i_cpu_state = '0;
    i_cpu_out = '0; i_cpu_halt = 1'b0;
    step(); step();
    check("rst_host_ready", o_host_ready, 1);
    check("rst_count", o_fifo_count, 0);
    check("rst_enter", o_cpu_enter, 0);
    check("rst_out_valid", o_out_valid, 0);
    check("rst_out_data", o_out_data, 0);
    check("rst_cpu_in", o_cpu_in, 0);
    check("rst_halted", o_halted, 0);
    rst = 1'b0;
    step();

    // Single input with precise timing
    push(8'h2A, 1'b1);
    check("count_one", o_fifo_count, 1);
    i_cpu_state = 4'd5;
    step();
    check("present_cpu_in", o_cpu_in, sb_in.pop_front());
    check("present_enter_low", o_cpu_enter, 0);
    check("count_after_pop", o_fifo_count, 0);
    step(); check("strobe1", o_cpu_enter, 1);
    step(); check("strobe2", o_cpu_enter, 1);
    step(); check("strobe_end", o_cpu_enter, 0);
    n = 0;
    for (int i = 0; i < 5; i++) begin step(); if (o_cpu_enter) n++; end
    check("single_no_repeat", n, 0);
    i_cpu_state = 4'd2;
    step(); step();

    // Reset mid-strobe
    push(8'h33, 1'b1);
    push(8'h34, 1'b1);
    i_cpu_state = 4'd5;
    n = 0;
    while (!o_cpu_enter && n < 20) begin step(); n++; end
    check("mid_enter_up", o_cpu_enter, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_enter", o_cpu_enter, 0);
    check("mid_rst_count", o_fifo_count, 0);
    check("mid_rst_ready", o_host_ready, 1);
    sb_in.delete();
    i_cpu_state = 4'd0;
    step();
    rst = 1'b0;
    step();
    check("post_rst_enter", o_cpu_enter, 0);

    // Starvation
    i_cpu_state = 4'd5;
    #1;
    check("in_waiting_set", o_in_waiting, 1);
    push(8'h07, 1'b1);
    check("in_waiting_drop", o_in_waiting, 0);
    present_byte();

    // Full FIFO and in-order drain across pointer wrap
    i_cpu_state = 4'd0;
    for (int i = 0; i < DEPTH; i++) push(8'h10 + 8'(i), 1'b1);
    check("full_ready", o_host_ready, 0);
    check("full_count", o_fifo_count, DEPTH);
    push(8'h99, 1'b0);
    check("full_drop_count", o_fifo_count, DEPTH);
    for (int i = 0; i < DEPTH; i++) present_byte();
    check("drained", o_fifo_count, 0);
    check("drained_ready", o_host_ready, 1);

    // Output capture, single then back-to-back
    p0 = pulse_cnt;
    do_output(8'h5C);
    check("one_pulse", pulse_cnt - p0, 1);
    p0 = pulse_cnt;
    do_output(8'hA5);
    do_output(8'h3C);
    check("two_pulses", pulse_cnt - p0, 2);

    // Halt coinciding with output exit, FIFO holding data
    push(8'hA1, 1'b1);
    push(8'hA2, 1'b1);
    i_cpu_out   = 8'h3E;
    i_cpu_state = 4'd6;
    step();
    i_cpu_state = 4'd5;
    i_cpu_halt  = 1'b1;
    step();
    check("halted_set", o_halted, 1);
    check("halt_capture_valid", o_out_valid, 1);
    check("halt_capture_data", o_out_data, 8'h3E);
    check("halt_count", o_fifo_count, 2);
    i_cpu_halt = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin step(); if (o_cpu_enter) n++; end
    check("halt_no_enter", n, 0);
    check("halt_sticky", o_halted, 1);
    check("halt_fifo_kept", o_fifo_count, 2);
    check("halt_no_waiting", o_in_waiting, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/proc_io_console.md
Name: proc_io_console

Overview:
- Host-side end of the processor's user I/O interface (in/enter/out/halt).
- Queues input bytes from a host source and presents them on the processor's 8-bit input. Pulses enter only while the control unit sits in its input state.
- Captures each value the processor writes to its output port, and latches halt.
- Sits beside the processor top level, replacing switch/push-button stimulus on the board and in system benches.

Parameters:
- DEPTH, 8, input FIFO entries; power of 2, >=2.
- ST_INPUT, 4'd5, control-unit state code for "waiting for enter".
- ST_OUTPUT, 4'd6, control-unit state code for "writing output register".
- ENTER_CYCLES, 2, cycles enter is held high per byte; >=1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- host_data  in  8  byte to queue for the processor.
- host_valid  in  1  host_data valid.
- host_ready  out  1  FIFO not full; a push occurs when host_valid && host_ready.
- cpu_state  in  4  control-unit state code (DisplayState).
- cpu_out  in  8  processor output register.
- cpu_halt  in  1  processor halt.
- cpu_in  out  8  byte driven to the processor input.
- cpu_enter  out  1  enter strobe to the control unit.
- out_data  out  8  last captured processor output.
- out_valid  out  1  one-cycle pulse per capture.
- in_waiting  out  1  processor in ST_INPUT with FIFO empty.
- halted  out  1  sticky halt flag.
- fifo_count  out  $clog2(DEPTH)+1  entries queued.

Behaviour:
- Reset (async, any time, including mid-strobe): FIFO emptied, FSM=IDLE, all outputs 0, host_ready=1. No partial enter pulse survives reset.

Input FIFO:
- Circular buffer with wrap-around read/write pointers.
- Push when host_valid && host_ready. Pop only on the IDLE->PRESENT transition.
- A push and a pop in the same cycle leave fifo_count unchanged.
- When full, host_ready=0 and host_valid is ignored.

Input FSM:
- IDLE: cpu_enter=0. If cpu_state==ST_INPUT and the FIFO is non-empty and not halted: pop the head into the cpu_in register and go to PRESENT.
- PRESENT: one setup cycle; cpu_in is stable and cpu_enter=0. Go to STROBE.
- STROBE: cpu_enter=1 for exactly ENTER_CYCLES cycles, then go to WAIT_EXIT.
- WAIT_EXIT: cpu_enter=0 and cpu_in is held. When cpu_state!=ST_INPUT, go to IDLE. cpu_in keeps its last value in IDLE.
- HALTED: entered from any state on the cycle after cpu_halt is sampled 1. cpu_enter forced to 0; the state is left only via reset.
- A byte pushed while the FIFO is empty and the processor is waiting is presented on the cycle after it becomes visible in fifo_count.
- Exactly one byte is consumed per visit to ST_INPUT.

in_waiting:
- Combinational: (cpu_state==ST_INPUT) && FIFO empty && !halted.

Output capture:
- Registers the previous cpu_state.
- On the first cycle where prev==ST_OUTPUT and cpu_state!=ST_OUTPUT, sample cpu_out into out_data and pulse out_valid for 1 cycle.
- Capture latency: 1 cycle after exit from ST_OUTPUT.
- Back-to-back output instructions produce one pulse each.
- Output capture still operates on the exit cycle that coincides with halt assertion.

halted:
- Set the cycle after cpu_halt is sampled 1; sticky until reset.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, PRESENT, STROBE, WAIT_EXIT, HALTED);
  - default ST_INPUT/ST_OUTPUT codes, so the control unit and this block share one definition.
- One natural sub-module: io_fifo (parameterised DEPTH x 8 synchronous FIFO with count, full and empty).

Test Plan:
- Reset mid-STROBE: assert reset during cpu_enter=1 -> cpu_enter=0 immediately; fifo_count=0; host_ready=1.
- Single input: push 8'h2A, then hold cpu_state=5 -> cpu_in=8'h2A from PRESENT; cpu_enter high 2 cycles, starting 2 cycles after the pop; no second pulse until cpu_state leaves 5 and returns.
- Starvation: cpu_state=5 with FIFO empty -> in_waiting=1; push 8'h07 -> in_waiting drops, then enter pulse with cpu_in=8'h07.
- Full FIFO: push 8 bytes (0x10..0x17) with no ST_INPUT visits -> host_ready=0 and fifo_count=8; a 9th push is dropped; then 8 ST_INPUT visits -> bytes presented in order 0x10..0x17 (wrap exercised).
- Output capture: cpu_out=8'h5C, cpu_state 6->2 -> out_data=8'h5C with a single out_valid pulse; two consecutive 6->x->6->x sequences give two pulses.
- Halt: cpu_halt=1 while the FIFO holds data and cpu_state=5 -> halted=1 next cycle; cpu_enter stays 0; FIFO contents unchanged.
